// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage_pkg
//  Description : Shared constants, IF/ID operation encoding and helpers for
//                the instruction-fetch front end (if_stage / if_id_reg).
//  Revision    : 1.0 - initial release
// ============================================================================
package if_stage_pkg;

    // Width of the core-wide stall vector and the bits this stage looks at.
    localparam int c_STALL_W   = 6;
    localparam int c_STALL_PC  = 0;
    localparam int c_STALL_IF  = 1;
    localparam int c_STALL_ID  = 2;

    // Action taken by the IF/ID register on a given edge.
    typedef enum logic [1:0] {
        IFID_CAPTURE = 2'd0,
        IFID_BUBBLE  = 2'd1,
        IFID_HOLD    = 2'd2,
        IFID_FLUSH   = 2'd3
    } ifid_op_e;

    // A fetch address is misaligned when it is not word aligned.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage : if_stage_pkg
`default_nettype wire

// File: rtl/if_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg
//  Description : IF/ID pipeline register. Flush and bubble insert a NOP,
//                a stall of both IF and ID holds, otherwise the fetched
//                PC / instruction / misalign flag are captured.
//  Ports       : clk, rst            - clock, sync active-high reset
//                flush_i             - exception flush (highest priority)
//                stall_if_i/id_i     - stall of IF and of ID
//                pc_i, inst_i, adel_i- values to capture from fetch
//                id_pc_o, id_inst_o, id_adel_o - register contents
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              stall_if_i,
    input  logic              stall_id_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [INST_W-1:0] inst_i,
    input  logic              adel_i,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic              id_adel_o
);

    ifid_op_e w_op;

    always_comb begin
        w_op = IFID_CAPTURE;
        if (flush_i) begin
            w_op = IFID_FLUSH;
        end else if (stall_if_i && !stall_id_i) begin
            // IF is stalled but ID advances: feed ID a NOP.
            w_op = IFID_BUBBLE;
        end else if (stall_if_i) begin
            w_op = IFID_HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_pc_o   <= '0;
            id_inst_o <= '0;
            id_adel_o <= 1'b0;
        end else begin
            case (w_op)
                IFID_FLUSH, IFID_BUBBLE: begin
                    id_pc_o   <= '0;
                    id_inst_o <= '0;
                    id_adel_o <= 1'b0;
                end
                IFID_HOLD: begin
                    id_pc_o   <= id_pc_o;
                    id_inst_o <= id_inst_o;
                    id_adel_o <= id_adel_o;
                end
                default: begin
                    id_pc_o   <= pc_i;
                    id_inst_o <= inst_i;
                    id_adel_o <= adel_i;
                end
            endcase
        end
    end

endmodule : if_id_reg
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : Instruction-fetch front end: PC register, ROM interface
//                and IF/ID pipeline register. Handles stall, taken branch
//                from ID and exception flush/redirect.
//  Ports       : clk, rst                 - clock, sync active-high reset
//                stall_i[5:0]             - stall vector (bits 0..2 used)
//                flush_i, new_pc_i        - exception flush and redirect
//                branch_flag_i/target_i   - taken branch from ID
//                rom_data_i               - combinational ROM read data
//                rom_addr_o, rom_ce_o     - ROM address (= PC) and enable
//                id_pc_o, id_inst_o, id_adel_o - IF/ID contents to decode
//  Revision    : 1.0 - initial release
// ============================================================================
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32,
    parameter int          INST_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [c_STALL_W-1:0] stall_i,
    input  logic                 flush_i,
    input  logic [ADDR_W-1:0]    new_pc_i,
    input  logic                 branch_flag_i,
    input  logic [ADDR_W-1:0]    branch_target_i,
    input  logic [INST_W-1:0]    rom_data_i,
    output logic [ADDR_W-1:0]    rom_addr_o,
    output logic                 rom_ce_o,
    output logic [ADDR_W-1:0]    id_pc_o,
    output logic [INST_W-1:0]    id_inst_o,
    output logic                 id_adel_o
);

    logic [ADDR_W-1:0] r_pc;
    logic              r_ce;
    logic [ADDR_W-1:0] w_pc_next;
    logic [INST_W-1:0] w_fetch_inst;
    logic              w_fetch_adel;
    logic              w_stall_unused;

    // Later-stage stall bits are not relevant to fetch.
    assign w_stall_unused = ^stall_i[c_STALL_W-1:c_STALL_ID+1];

    // Next PC while fetching. Flush overrides stall; a branch presented
    // during a PC stall is dropped, ID keeps it asserted until released.
    always_comb begin
        w_pc_next = r_pc + ADDR_W'(4);
        if (flush_i) begin
            w_pc_next = new_pc_i;
        end else if (stall_i[c_STALL_PC]) begin
            w_pc_next = r_pc;
        end else if (branch_flag_i) begin
            w_pc_next = branch_target_i;
        end
    end

    // Chip enable rises one edge after reset release; until then the PC
    // parks on RESET_PC so the first real fetch is RESET_PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ce <= 1'b0;
            r_pc <= ADDR_W'(RESET_PC);
        end else begin
            r_ce <= 1'b1;
            if (r_ce) begin
                r_pc <= w_pc_next;
            end else begin
                r_pc <= ADDR_W'(RESET_PC);
            end
        end
    end

    assign rom_addr_o = r_pc;
    assign rom_ce_o   = r_ce;

    // Disabled ROM yields a NOP; misaligned fetches go ahead and are flagged.
    assign w_fetch_inst = r_ce ? rom_data_i : '0;
    assign w_fetch_adel = is_misaligned(r_pc[1:0]) & r_ce;

    if_id_reg #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .stall_if_i (stall_i[c_STALL_IF]),
        .stall_id_i (stall_i[c_STALL_ID]),
        .pc_i       (r_pc),
        .inst_i     (w_fetch_inst),
        .adel_i     (w_fetch_adel),
        .id_pc_o    (id_pc_o),
        .id_inst_o  (id_inst_o),
        .id_adel_o  (id_adel_o)
    );

endmodule : if_stage
`default_nettype wire
